// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite decoder definitions: response codes, FSM state encodings
// and the index-width helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_1ton_decoder_if.sv
// One upstream AXI4-Lite port (m_*) plus N packed downstream ports (s_*),
// slave i at slice i of every s_* signal.
interface axi_lite_1ton_decoder_if #(
    parameter int N_SLAVES = 2
);
    // Every channel completes on a cycle where valid and ready are both high;
    // valid never waits on ready, and the decoder only routes, never buffers.
    logic [31:0]             m_awaddr;
    logic [2:0]              m_awprot;
    logic                    m_awvalid;
    logic                    m_awready;
    logic [31:0]             m_wdata;
    logic [3:0]              m_wstrb;
    logic                    m_wvalid;
    logic                    m_wready;
    logic [1:0]              m_bresp;
    logic                    m_bvalid;
    logic                    m_bready;
    logic [31:0]             m_araddr;
    logic [2:0]              m_arprot;
    logic                    m_arvalid;
    logic                    m_arready;
    logic [31:0]             m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rvalid;
    logic                    m_rready;

    logic [N_SLAVES*32-1:0]  s_awaddr;
    logic [N_SLAVES*3-1:0]   s_awprot;
    logic [N_SLAVES-1:0]     s_awvalid;
    logic [N_SLAVES-1:0]     s_awready;
    logic [N_SLAVES*32-1:0]  s_wdata;
    logic [N_SLAVES*4-1:0]   s_wstrb;
    logic [N_SLAVES-1:0]     s_wvalid;
    logic [N_SLAVES-1:0]     s_wready;
    logic [N_SLAVES*2-1:0]   s_bresp;
    logic [N_SLAVES-1:0]     s_bvalid;
    logic [N_SLAVES-1:0]     s_bready;
    logic [N_SLAVES*32-1:0]  s_araddr;
    logic [N_SLAVES*3-1:0]   s_arprot;
    logic [N_SLAVES-1:0]     s_arvalid;
    logic [N_SLAVES-1:0]     s_arready;
    logic [N_SLAVES*32-1:0]  s_rdata;
    logic [N_SLAVES*2-1:0]   s_rresp;
    logic [N_SLAVES-1:0]     s_rvalid;
    logic [N_SLAVES-1:0]     s_rready;

    modport slave (
        input  m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_araddr, m_arprot, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
        output s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arprot, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_araddr, m_arprot, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
        input  s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arprot, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching index wins.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int                     N_SLAVES  = 2,
    parameter logic [N_SLAVES*32-1:0] ADDR_BASE = {32'h4000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] ADDR_MASK = {2{32'hFFFF_0000}},
    localparam int                    IDX_W     = (N_SLAVES > 1) ? clog2(N_SLAVES) : 1
) (
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] index,
    output logic             hit,
    output logic             decerr
);

    always_comb begin
        index = '0;
        hit   = 1'b0;
        // Scan downwards so the last assignment is the lowest matching index.
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
                index = IDX_W'(i);
                hit   = 1'b1;
            end
        end
        decerr = ~hit;
    end

endmodule

// File: rtl/axi_lite_1ton_decoder.sv
// AXI4-Lite 1-to-N address decoder with independent write and read FSMs,
// combinational channel routing and an internal DECERR responder.
module axi_lite_1ton_decoder
    import axi_lite_pkg::*;
#(
    parameter int                     N_SLAVES  = 2,
    parameter logic [N_SLAVES*32-1:0] ADDR_BASE = {32'h4000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] ADDR_MASK = {2{32'hFFFF_0000}},
    localparam int                    IDX_W     = (N_SLAVES > 1) ? clog2(N_SLAVES) : 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    axi_lite_1ton_decoder_if.slave        bus,
    output wr_state_t                     wr_state,
    output rd_state_t                     rd_state
);

    logic [IDX_W-1:0] aw_idx, ar_idx, wr_idx, rd_idx;
    logic             aw_hit, ar_hit, aw_dec, ar_dec, wr_dec, rd_dec;

    axi_lite_addr_decode #(.N_SLAVES(N_SLAVES), .ADDR_BASE(ADDR_BASE), .ADDR_MASK(ADDR_MASK)) u_aw_decode (
        .addr(bus.m_awaddr), .index(aw_idx), .hit(aw_hit), .decerr(aw_dec)
    );

    axi_lite_addr_decode #(.N_SLAVES(N_SLAVES), .ADDR_BASE(ADDR_BASE), .ADDR_MASK(ADDR_MASK)) u_ar_decode (
        .addr(bus.m_araddr), .index(ar_idx), .hit(ar_hit), .decerr(ar_dec)
    );

    assign bus.s_awaddr = {N_SLAVES{bus.m_awaddr}};
    assign bus.s_awprot = {N_SLAVES{bus.m_awprot}};
    assign bus.s_wdata  = {N_SLAVES{bus.m_wdata}};
    assign bus.s_wstrb  = {N_SLAVES{bus.m_wstrb}};
    assign bus.s_araddr = {N_SLAVES{bus.m_araddr}};
    assign bus.s_arprot = {N_SLAVES{bus.m_arprot}};

    // Write channel routing; gated by aresetn so nothing handshakes while in reset.
    always_comb begin
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = RESP_OKAY;
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
        bus.s_bready  = '0;
        if (aresetn) begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hit) begin
                        bus.s_awvalid[aw_idx] = bus.m_awvalid;
                        bus.m_awready         = bus.s_awready[aw_idx];
                    end else begin
                        bus.m_awready = 1'b1;
                    end
                end
                W_DATA: begin
                    if (wr_dec) begin
                        bus.m_wready = 1'b1;
                    end else begin
                        bus.s_wvalid[wr_idx] = bus.m_wvalid;
                        bus.m_wready         = bus.s_wready[wr_idx];
                    end
                end
                W_RESP: begin
                    if (wr_dec) begin
                        bus.m_bvalid = 1'b1;
                        bus.m_bresp  = RESP_DECERR;
                    end else begin
                        bus.m_bvalid         = bus.s_bvalid[wr_idx];
                        bus.m_bresp          = bus.s_bresp[2*wr_idx +: 2];
                        bus.s_bready[wr_idx] = bus.m_bready;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = RESP_OKAY;
        bus.s_arvalid = '0;
        bus.s_rready  = '0;
        if (aresetn) begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hit) begin
                        bus.s_arvalid[ar_idx] = bus.m_arvalid;
                        bus.m_arready         = bus.s_arready[ar_idx];
                    end else begin
                        bus.m_arready = 1'b1;
                    end
                end
                R_RESP: begin
                    if (rd_dec) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rresp  = RESP_DECERR;
                    end else begin
                        bus.m_rvalid         = bus.s_rvalid[rd_idx];
                        bus.m_rdata          = bus.s_rdata[32*rd_idx +: 32];
                        bus.m_rresp          = bus.s_rresp[2*rd_idx +: 2];
                        bus.s_rready[rd_idx] = bus.m_rready;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            wr_idx   <= '0;
            wr_dec   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (bus.m_awvalid && bus.m_awready) begin
                    wr_idx   <= aw_idx;
                    wr_dec   <= aw_dec;
                    wr_state <= W_DATA;
                end
                W_DATA: if (bus.m_wvalid && bus.m_wready) wr_state <= W_RESP;
                W_RESP: if (bus.m_bvalid && bus.m_bready) wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
            rd_dec   <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: if (bus.m_arvalid && bus.m_arready) begin
                    rd_idx   <= ar_idx;
                    rd_dec   <= ar_dec;
                    rd_state <= R_RESP;
                end
                R_RESP: if (bus.m_rvalid && bus.m_rready) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_1ton_decoder.sv
// Directed bench for the 1-to-N decoder: three slaves plus a standalone
// overlapping-range decoder for lowest-index priority.
module tb_axi_lite_1ton_decoder;
    import axi_lite_pkg::*;

    localparam int               N     = 3;
    localparam logic [N*32-1:0]  BASES = {32'h4001_0000, 32'h4000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0]  MASKS = {3{32'hFFFF_0000}};
    localparam logic [N*32-1:0]  OV_BASES = {32'h4001_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0]  OV_MASKS = {32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000};

    logic      aclk;
    logic      aresetn;
    wr_state_t dut_wr_state;
    rd_state_t dut_rd_state;
    logic [31:0] ov_addr;
    logic [1:0]  ov_idx;
    logic        ov_hit;
    logic        ov_decerr;

    int n_checks;
    int n_fail;

    axi_lite_1ton_decoder_if #(.N_SLAVES(N)) bus ();

    axi_lite_1ton_decoder #(.N_SLAVES(N), .ADDR_BASE(BASES), .ADDR_MASK(MASKS)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus), .wr_state(dut_wr_state), .rd_state(dut_rd_state)
    );

    axi_lite_addr_decode #(.N_SLAVES(N), .ADDR_BASE(OV_BASES), .ADDR_MASK(OV_MASKS)) u_ov (
        .addr(ov_addr), .index(ov_idx), .hit(ov_hit), .decerr(ov_decerr)
    );

    // clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_all();
        bus.m_awaddr = '0; bus.m_awprot = '0; bus.m_awvalid = 1'b0;
        bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_wvalid = 1'b0; bus.m_bready = 1'b0;
        bus.m_araddr = '0; bus.m_arprot = '0; bus.m_arvalid = 1'b0; bus.m_rready = 1'b0;
        bus.s_awready = '0; bus.s_wready = '0; bus.s_bresp = '0; bus.s_bvalid = '0;
        bus.s_arready = '0; bus.s_rdata = '0; bus.s_rresp = '0; bus.s_rvalid = '0;
        ov_addr = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_all();
        aresetn = 1'b0;

        // reset: outputs quiet even with every input asserted
        bus.m_awvalid = 1'b1; bus.m_awaddr = 32'h4000_0000;
        bus.m_arvalid = 1'b1; bus.m_araddr = 32'h4000_0000;
        bus.m_wvalid = 1'b1; bus.m_bready = 1'b1; bus.m_rready = 1'b1;
        bus.s_awready = '1; bus.s_wready = '1; bus.s_arready = '1;
        bus.s_bvalid = '1; bus.s_rvalid = '1; bus.s_bresp = '1; bus.s_rresp = '1;
        bus.s_rdata = {3{32'hDEAD_BEEF}};
        #3;
        check("rst_awready", 64'(bus.m_awready), 64'd0);
        check("rst_arready", 64'(bus.m_arready), 64'd0);
        check("rst_wready",  64'(bus.m_wready),  64'd0);
        check("rst_bvalid",  64'(bus.m_bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.m_rvalid),  64'd0);
        check("rst_s_awvalid", 64'(bus.s_awvalid), 64'd0);
        check("rst_s_arvalid", 64'(bus.s_arvalid), 64'd0);
        check("rst_rdata",   64'(bus.m_rdata),   64'd0);
        check("rst_resps",   64'({bus.m_bresp, bus.m_rresp}), 64'd0);
        check("rst_wr_state", 64'(dut_wr_state), 64'(W_IDLE));
        #20;
        clear_all();
        aresetn = 1'b1;
        tick();

        // write 0x4001_0008 -> slave 2 only
        bus.s_awready = '1; bus.s_wready = '1;
        bus.m_awaddr = 32'h4001_0008; bus.m_awvalid = 1'b1;
        bus.m_wdata = 32'hCAFE_F00D; bus.m_wstrb = 4'hF; bus.m_wvalid = 1'b1;
        settle();
        check("t1_s_awvalid", 64'(bus.s_awvalid), 64'b100);
        check("t1_awready", 64'(bus.m_awready), 64'd1);
        check("t1_wready_idle", 64'(bus.m_wready), 64'd0);
        check("t1_awaddr_bcast", 64'(bus.s_awaddr[0 +: 32]), 64'h4001_0008);
        tick();
        bus.m_awvalid = 1'b0;
        settle();
        check("t1_s_wvalid", 64'(bus.s_wvalid), 64'b100);
        check("t1_wready", 64'(bus.m_wready), 64'd1);
        check("t1_wdata", 64'(bus.s_wdata[64 +: 32]), 64'hCAFE_F00D);
        tick();
        bus.m_wvalid = 1'b0;
        bus.s_bvalid = 3'b100; bus.s_bresp = {2'b00, 2'b10, 2'b10}; bus.m_bready = 1'b1;
        settle();
        check("t1_bvalid", 64'(bus.m_bvalid), 64'd1);
        check("t1_bresp", 64'(bus.m_bresp), 64'(RESP_OKAY));
        check("t1_s_bready", 64'(bus.s_bready), 64'b100);
        tick();
        check("t1_wr_idle", 64'(dut_wr_state), 64'(W_IDLE));
        check("t1_bvalid_idle", 64'(bus.m_bvalid), 64'd0);
        clear_all();

        // read unmapped 0x8000_0000 -> internal DECERR
        bus.s_arready = '1;
        bus.m_araddr = 32'h8000_0000; bus.m_arvalid = 1'b1;
        settle();
        check("t2_arready", 64'(bus.m_arready), 64'd1);
        check("t2_s_arvalid", 64'(bus.s_arvalid), 64'd0);
        tick();
        bus.m_arvalid = 1'b0;
        bus.s_rvalid = '1; bus.s_rdata = {3{32'hDEAD_BEEF}}; bus.m_rready = 1'b1;
        settle();
        check("t2_rvalid", 64'(bus.m_rvalid), 64'd1);
        check("t2_rdata", 64'(bus.m_rdata), 64'd0);
        check("t2_rresp", 64'(bus.m_rresp), 64'(RESP_DECERR));
        check("t2_s_rready", 64'(bus.s_rready), 64'd0);
        tick();
        check("t2_rvalid_idle", 64'(bus.m_rvalid), 64'd0);
        check("t2_rd_idle", 64'(dut_rd_state), 64'(R_IDLE));
        clear_all();

        // W before AW: held until AW accepted, then reaches slave 1 only
        bus.s_awready = '1; bus.s_wready = '1;
        bus.m_wvalid = 1'b1; bus.m_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_early_wready", 64'(bus.m_wready), 64'd0);
            check("t3_early_s_wvalid", 64'(bus.s_wvalid), 64'd0);
            tick();
        end
        bus.m_awaddr = 32'h4000_0004; bus.m_awvalid = 1'b1;
        settle();
        check("t3_s_awvalid", 64'(bus.s_awvalid), 64'b010);
        check("t3_wready_aw", 64'(bus.m_wready), 64'd0);
        tick();
        bus.m_awvalid = 1'b0;
        settle();
        check("t3_s_wvalid", 64'(bus.s_wvalid), 64'b010);
        check("t3_wready", 64'(bus.m_wready), 64'd1);
        tick();
        bus.m_wvalid = 1'b0;
        bus.s_bvalid = 3'b010; bus.s_bresp = {2'b00, RESP_SLVERR, 2'b00}; bus.m_bready = 1'b1;
        settle();
        check("t3_bresp", 64'(bus.m_bresp), 64'(RESP_SLVERR));
        tick();
        clear_all();

        // slave 0 stalls B for 5 cycles while a read of slave 1 completes
        bus.s_awready = '1; bus.s_wready = '1; bus.s_arready = '1; bus.m_bready = 1'b1;
        bus.m_awaddr = 32'h0000_0010; bus.m_awvalid = 1'b1;
        bus.m_wvalid = 1'b1; bus.m_wdata = 32'h5555_AAAA;
        settle();
        check("t4_s_awvalid", 64'(bus.s_awvalid), 64'b001);
        tick();
        bus.m_awaddr = 32'h0000_0020;
        settle();
        check("t4_awready_data", 64'(bus.m_awready), 64'd0);
        check("t4_s_wvalid", 64'(bus.s_wvalid), 64'b001);
        tick();
        bus.m_wvalid = 1'b0;
        bus.m_araddr = 32'h4000_0100; bus.m_arvalid = 1'b1;
        settle();
        check("t4_s_arvalid", 64'(bus.s_arvalid), 64'b010);
        check("t4_arready", 64'(bus.m_arready), 64'd1);
        check("t4_awready_r0", 64'(bus.m_awready), 64'd0);
        tick();
        bus.m_arvalid = 1'b0;
        bus.s_rvalid = 3'b010; bus.m_rready = 1'b1;
        bus.s_rdata = {32'h0000_0000, 32'hA5A5_0001, 32'hFFFF_FFFF};
        bus.s_rresp = {2'b11, RESP_OKAY, 2'b11};
        settle();
        check("t4_rvalid", 64'(bus.m_rvalid), 64'd1);
        check("t4_rdata", 64'(bus.m_rdata), 64'hA5A5_0001);
        check("t4_rresp", 64'(bus.m_rresp), 64'(RESP_OKAY));
        check("t4_s_rready", 64'(bus.s_rready), 64'b010);
        check("t4_awready_r1", 64'(bus.m_awready), 64'd0);
        tick();
        bus.s_rvalid = '0; bus.m_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t4_awready_wait", 64'(bus.m_awready), 64'd0);
            check("t4_bvalid_wait", 64'(bus.m_bvalid), 64'd0);
            check("t4_wr_resp", 64'(dut_wr_state), 64'(W_RESP));
            tick();
        end
        bus.s_bvalid = 3'b001; bus.s_bresp = '0;
        settle();
        check("t4_bvalid", 64'(bus.m_bvalid), 64'd1);
        check("t4_awready_b", 64'(bus.m_awready), 64'd0);
        tick();
        check("t4_awready_after", 64'(bus.m_awready), 64'd1);
        check("t4_s_awvalid2", 64'(bus.s_awvalid), 64'b001);
        clear_all();
        tick();

        // asynchronous reset in W_DATA, then a fresh write to slave 0
        bus.s_awready = '1; bus.s_wready = '1;
        bus.m_awaddr = 32'h4000_0000; bus.m_awvalid = 1'b1;
        settle();
        tick();
        bus.m_wvalid = 1'b1;
        settle();
        check("t5_wready_pre", 64'(bus.m_wready), 64'd1);
        check("t5_s_wvalid_pre", 64'(bus.s_wvalid), 64'b010);
        #2;
        aresetn = 1'b0;
        #1;
        check("t5_wready_rst", 64'(bus.m_wready), 64'd0);
        check("t5_s_wvalid_rst", 64'(bus.s_wvalid), 64'd0);
        check("t5_awready_rst", 64'(bus.m_awready), 64'd0);
        check("t5_s_awvalid_rst", 64'(bus.s_awvalid), 64'd0);
        check("t5_wr_state_rst", 64'(dut_wr_state), 64'(W_IDLE));
        #1;
        aresetn = 1'b1;
        bus.m_awvalid = 1'b0; bus.m_wvalid = 1'b0;
        tick();
        bus.m_awaddr = 32'h0000_0010; bus.m_awvalid = 1'b1;
        bus.m_wvalid = 1'b1; bus.m_wdata = 32'h0BAD_CAFE;
        settle();
        check("t5_s_awvalid", 64'(bus.s_awvalid), 64'b001);
        check("t5_s_wvalid_idle", 64'(bus.s_wvalid), 64'd0);
        tick();
        bus.m_awvalid = 1'b0;
        settle();
        check("t5_s_wvalid", 64'(bus.s_wvalid), 64'b001);
        tick();
        bus.m_wvalid = 1'b0;
        bus.s_bvalid = 3'b001; bus.m_bready = 1'b1;
        settle();
        check("t5_bvalid", 64'(bus.m_bvalid), 64'd1);
        tick();
        clear_all();

        // overlapping ranges: slave 1 matches everything, lower index wins
        ov_addr = 32'h0000_0020;
        settle();
        check("ov_idx_low", 64'(ov_idx), 64'd0);
        check("ov_hit_low", 64'(ov_hit), 64'd1);
        ov_addr = 32'h4000_0000;
        settle();
        check("ov_idx_mid", 64'(ov_idx), 64'd1);
        ov_addr = 32'h4001_0004;
        settle();
        check("ov_idx_over2", 64'(ov_idx), 64'd1);
        ov_addr = 32'h8000_0000;
        settle();
        check("ov_decerr", 64'(ov_decerr), 64'd0);

        // simultaneous AW and AR to the same slave
        tick();
        bus.s_awready = '1; bus.s_arready = '1;
        bus.m_awaddr = 32'h4000_0000; bus.m_awvalid = 1'b1;
        bus.m_araddr = 32'h4000_0000; bus.m_arvalid = 1'b1;
        settle();
        check("t7_s_awvalid", 64'(bus.s_awvalid), 64'b010);
        check("t7_s_arvalid", 64'(bus.s_arvalid), 64'b010);
        check("t7_readies", 64'({bus.m_awready, bus.m_arready}), 64'b11);
        tick();
        bus.m_awvalid = 1'b0; bus.m_arvalid = 1'b0;
        settle();
        check("t7_wr_state", 64'(dut_wr_state), 64'(W_DATA));
        check("t7_rd_state", 64'(dut_rd_state), 64'(R_RESP));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_1ton_decoder.md
AXI_LITE_1TON_DECODER -- requirements
Module: axi_lite_1ton_decoder

Interface
REQ-001 Parameter N_SLAVES, default 2: number of slave ports, legal range 1..8.
REQ-002 Parameter ADDR_BASE, default {32'h4000_0000, 32'h0000_0000}: packed N_SLAVES x 32 bases, slave i at bits [32i+31:32i].
REQ-003 Parameter ADDR_MASK, default {2{32'hFFFF_0000}}: packed N_SLAVES x 32 masks, same packing.
REQ-004 aclk  in  1  sole clock; all state on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 M_AW*/M_W*/M_B*/M_AR*/M_R*  AXI4-Lite slave-side port, 32-bit addr/data, 3-bit PROT, 4-bit WSTRB, 2-bit RESP.
REQ-007 S_AW*/S_W*/S_B*/S_AR*/S_R*  master-side ports, each signal packed N_SLAVES x width, slave i at slice i.

Function
REQ-008 Decode: slave i matches when (addr & ADDR_MASK[i]) == ADDR_BASE[i]; on multiple matches the lowest index wins; no match means DECERR target.
REQ-009 ADDR, PROT, WDATA and WSTRB SHALL broadcast to all slaves; only VALID is gated per slave.
REQ-010 Write FSM states: W_IDLE, W_DATA, W_RESP.
REQ-011 W_IDLE: S_AWVALID[t]=M_AWVALID for decoded target t; M_AWREADY=S_AWREADY[t]; DECERR target gives M_AWREADY=1. On AW handshake, latch target index and DECERR flag, go to W_DATA.
REQ-012 W_DATA: S_WVALID[latched]=M_WVALID, M_WREADY=S_WREADY[latched]; DECERR gives M_WREADY=1. On W handshake, go to W_RESP.
REQ-013 W_RESP: M_BVALID/M_BRESP=S_BVALID/S_BRESP[latched], S_BREADY[latched]=M_BREADY; DECERR gives M_BVALID=1, M_BRESP=2'b11. On B handshake, go to W_IDLE.
REQ-014 M_WREADY=0 outside W_DATA; a W beat presented before AW waits, is not dropped, and is not misrouted.
REQ-015 Read FSM states: R_IDLE, R_RESP. R_IDLE routes AR as in REQ-011 and latches target on AR handshake. R_RESP muxes RVALID/RDATA/RRESP from the latched slave; DECERR gives M_RVALID=1, M_RDATA=0, M_RRESP=2'b11. On R handshake, go to R_IDLE.
REQ-016 At most one outstanding write and one outstanding read; M_AWREADY=0 outside W_IDLE, M_ARREADY=0 outside R_IDLE.
REQ-017 Read and write FSMs are fully independent; simultaneous AW and AR to the same or different slaves both proceed.
REQ-018 All non-selected S_*VALID/S_*READY outputs are 0; M_BVALID=0 outside W_RESP; M_RVALID=0 and M_RDATA=0 outside R_RESP.
REQ-019 Handshake-to-handshake latency is combinational pass-through; the decoder adds no wait cycles beyond the FSM phase order.
REQ-020 A late slave BVALID/RVALID SHALL be held off by the slave (S_*READY=0) until the FSM reaches the response state.

Reset
REQ-021 aresetn low: both FSMs go to IDLE and latched index/DECERR flags clear to 0, immediately and asynchronously.
REQ-022 During reset, all M_*READY, M_BVALID, M_RVALID and S_*VALID are 0, and M_BRESP, M_RRESP and M_RDATA are 0.
REQ-023 Reset mid-transaction abandons it; the first post-reset transaction decodes afresh.

Structure
REQ-024 Shared package axi_lite_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, the FSM state encodings, and the index width function clog2.
REQ-025 Sub-module axi_lite_addr_decode (combinational): addr in; index, hit and decerr out; instantiated once for AW and once for AR.

Verification
REQ-026 N=3, bases 0x0000_0000/0x4000_0000/0x4001_0000, masks 0xFFFF_0000. Write 0x4001_0008 data 0xCAFE_F00D -> only S_AWVALID[2]/S_WVALID[2] assert, BRESP=2'b00.
REQ-027 Read 0x8000_0000 -> M_ARREADY=1 same cycle, next cycle M_RVALID=1, RDATA=0, RRESP=2'b11, no S_ARVALID asserts.
REQ-028 WVALID raised 3 cycles before AWVALID to 0x4000_0004 -> M_WREADY=0 until AW accepted, then W reaches slave 1 only.
REQ-029 Slave 0 holds BVALID low 5 cycles while read of slave 1 runs -> read completes; M_AWREADY stays 0 until B accepted.
REQ-030 aresetn dropped in W_DATA mid-cycle -> M_WREADY and S_WVALID fall without waiting for a clock; after release, write to 0x0000_0010 routes to slave 0.
REQ-031 Overlap test with ADDR_MASK[1]=0x0000_0000 and access 0x0000_0020 -> slave 0 selected (lowest index wins).
